// File: rtl/fft_input_loader_pkg.sv
// Shared FFT package: loader states, bit reversal, sample extension rule.
// Defining INPUT_PRESCALE_EN turns on the input left shift.
package fft_input_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        BUSY
    } state_t;

    localparam int MAX_SIZE = 16;

`ifdef INPUT_PRESCALE_EN
    localparam bit PRESCALE_ON = 1'b1;
`else
    localparam bit PRESCALE_ON = 1'b0;
`endif

    // Reverses the low `size` bits; the result sits in the low bits.
    function automatic logic [MAX_SIZE-1:0] bit_reverse(
        input logic [MAX_SIZE-1:0] v,
        input int                  size
    );
        logic [MAX_SIZE-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_SIZE; k++) begin
            if (k < size) r[k] = v[size-1-k];
        end
        return r;
    endfunction

    function automatic int prescale_shift(input int prescale);
        return PRESCALE_ON ? prescale : 0;
    endfunction

    // A shifted, sign-extended sample must still fit the datapath.
    function automatic bit ext_fits(
        input int in_w,
        input int out_w,
        input int shift
    );
        return (in_w + shift) <= out_w;
    endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Valid/ready sample stream into the FFT input loader.
// Carries frame start marker and signed complex sample.
interface fft_input_loader_if #(
    parameter int in_width = 16
) ();

    logic                       valid;
    logic                       ready;
    logic                       sop;
    logic signed [in_width-1:0] re;
    logic signed [in_width-1:0] im;

    modport master (
        output valid,
        output sop,
        output re,
        output im,
        input  ready
    );

    modport slave (
        input  valid,
        input  sop,
        input  re,
        input  im,
        output ready
    );

endinterface

// File: rtl/fft_bitrev_counter.sv
// Frame index counter with terminal flag and bit-reversed view.
// Clear wins over load-one, which wins over increment.
module fft_bitrev_counter
    import fft_input_loader_pkg::*;
#(
    parameter int N    = 16,
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load_one,
    input  logic            inc,
    output logic            last,
    output logic [SIZE-1:0] rev
);

    logic [SIZE-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= SIZE'(1);
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == SIZE'(N - 1));
    assign rev  = SIZE'(bit_reverse(MAX_SIZE'(cnt), SIZE));

endmodule

// File: rtl/fft_input_loader.sv
// FFT front end: frame alignment, bit-reversed RAM fill, stage start.
// Define INPUT_PRESCALE_EN to shift samples left by PRESCALE.
module fft_input_loader
    import fft_input_loader_pkg::*;
#(
    parameter int bit_width = 24,
    parameter int in_width  = 16,
    parameter int N         = 16,
    parameter int SIZE      = 4,
    parameter int PRESCALE  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fft_input_loader_if.slave           src,
    input  logic                        frame_done_i,
    output logic                        valid_o,
    output logic signed [bit_width-1:0] Re_o,
    output logic signed [bit_width-1:0] Im_o,
    output logic [SIZE-1:0]             wr_ptr_o,
    output logic                        start_o,
    output logic                        resync_o
);

    localparam int SHIFT =
        ext_fits(in_width, bit_width, prescale_shift(PRESCALE))
        ? prescale_shift(PRESCALE) : 0;

    state_t state;
    state_t state_nx;

    logic ready_q;
    logic done_pending;
    logic accept;
    logic write;
    logic cnt_clr;
    logic cnt_one;
    logic cnt_inc;
    logic last;
    logic [SIZE-1:0] rev;

    logic signed [in_width-1:0]  re_in;
    logic signed [in_width-1:0]  im_in;
    logic signed [bit_width-1:0] re_ext;
    logic signed [bit_width-1:0] im_ext;

    assign src.ready = ready_q;
    assign accept    = src.valid & ready_q;

    assign re_in  = src.re;
    assign im_in  = src.im;
    assign re_ext = bit_width'(re_in) <<< SHIFT;
    assign im_ext = bit_width'(im_in) <<< SHIFT;

    always_comb begin
        state_nx = state;
        write    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && src.sop) begin
                    write    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    write = 1'b1;
                    if (!src.sop && last) state_nx = START;
                end
            end
            START: state_nx = BUSY;
            BUSY: begin
                if (frame_done_i || done_pending) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cnt_clr = (state == START);
    assign cnt_one = write & src.sop;
    assign cnt_inc = write & ~src.sop;

    fft_bitrev_counter #(
        .N   (N),
        .SIZE(SIZE)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst_n),
        .clr     (cnt_clr),
        .load_one(cnt_one),
        .inc     (cnt_inc),
        .last    (last),
        .rev     (rev)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            done_pending <= 1'b0;
            valid_o      <= 1'b0;
            Re_o         <= '0;
            Im_o         <= '0;
            wr_ptr_o     <= '0;
            start_o      <= 1'b0;
            resync_o     <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == IDLE) || (state_nx == LOAD);
            // Early completion during START must survive into BUSY.
            if (state == START && frame_done_i) begin
                done_pending <= 1'b1;
            end else if (state_nx == IDLE) begin
                done_pending <= 1'b0;
            end
            valid_o  <= write;
            resync_o <= write & src.sop & (state == LOAD);
            start_o  <= (state == START);
            if (write) begin
                Re_o     <= re_ext;
                Im_o     <= im_ext;
                wr_ptr_o <= src.sop ? '0 : rev;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader (N=16).
// Expected sample scaling follows INPUT_PRESCALE_EN.
module tb_fft_input_loader;

    localparam int BW = 24;
    localparam int IW = 16;
    localparam int SZ = 4;

`ifdef INPUT_PRESCALE_EN
    localparam int SCALE = 16;
    localparam int EXP_MIN = -524288;
    localparam int EXP_MAX = 524272;
`else
    localparam int SCALE = 1;
    localparam int EXP_MIN = -32768;
    localparam int EXP_MAX = 32767;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic frame_done = 1'b0;
    logic valid_o;
    logic start_o;
    logic resync_o;
    logic signed [BW-1:0] re_o;
    logic signed [BW-1:0] im_o;
    logic [SZ-1:0] wr_ptr;

    int checks = 0;
    int fails = 0;
    int rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                         1, 9, 5, 13, 3, 11, 7, 15};

    fft_input_loader_if #(.in_width(IW)) src_if ();

    always #5 clk = ~clk;

    fft_input_loader #(
        .bit_width(BW),
        .in_width (IW),
        .N        (16),
        .SIZE     (SZ),
        .PRESCALE (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src         (src_if),
        .frame_done_i(frame_done),
        .valid_o     (valid_o),
        .Re_o        (re_o),
        .Im_o        (im_o),
        .wr_ptr_o    (wr_ptr),
        .start_o     (start_o),
        .resync_o    (resync_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s,
                         input int re, input int im);
        src_if.valid = v;
        src_if.sop   = s;
        src_if.re    = IW'(re);
        src_if.im    = IW'(im);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        step();
        step();
        checks++;
        if (src_if.ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got %b exp 0", src_if.ready);
        end
        checks++;
        if (valid_o !== 1'b0 || start_o !== 1'b0 || resync_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes got %b%b%b exp 000",
                     valid_o, start_o, resync_o);
        end
        checks++;
        if (re_o !== '0 || im_o !== '0 || wr_ptr !== '0) begin
            fails++;
            $display("FAIL reset_data got %0d %0d %0d exp 0 0 0",
                     re_o, im_o, wr_ptr);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (src_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready got %b exp 1", src_if.ready);
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (src_if.ready !== 1'b1) begin
                fails++;
                $display("FAIL frame_ready i=%0d got 0 exp 1", i);
            end
            drive(1, i == 0, i, -i);
            step();
            checks++;
            if (valid_o !== 1'b1 || wr_ptr !== SZ'(rev_tab[i])) begin
                fails++;
                $display("FAIL frame_ptr i=%0d got v=%b p=%0d exp v=1 p=%0d",
                         i, valid_o, wr_ptr, rev_tab[i]);
            end
            checks++;
            if (re_o !== BW'(i * SCALE) || im_o !== BW'(-i * SCALE)) begin
                fails++;
                $display("FAIL frame_data i=%0d got %0d %0d exp %0d %0d",
                         i, re_o, im_o, i * SCALE, -i * SCALE);
            end
            checks++;
            if (start_o !== 1'b0) begin
                fails++;
                $display("FAIL frame_early_start i=%0d got 1 exp 0", i);
            end
        end
        checks++;
        if (src_if.ready !== 1'b0) begin
            fails++;
            $display("FAIL frame_ready_drop got 1 exp 0");
        end
        drive(1, 0, 55, 55);
        step();
        checks++;
        if (start_o !== 1'b1 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL frame_start got s=%b v=%b exp s=1 v=0",
                     start_o, valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (start_o !== 1'b0 || valid_o !== 1'b0 ||
                src_if.ready !== 1'b0) begin
                fails++;
                $display("FAIL busy_hold k=%0d got s=%b v=%b r=%b exp 000",
                         k, start_o, valid_o, src_if.ready);
            end
        end
        drive(0, 0, 0, 0);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        checks++;
        if (src_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL done_in_busy_ready got 0 exp 1");
        end
    endtask

    task automatic test_idle_discard();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 100 + k, 0);
            step();
            checks++;
            if (valid_o !== 1'b0 || resync_o !== 1'b0) begin
                fails++;
                $display("FAIL idle_discard k=%0d got v=%b exp 0", k, valid_o);
            end
        end
        drive(1, 1, 7, -7);
        step();
        checks++;
        if (valid_o !== 1'b1 || wr_ptr !== '0 || re_o !== BW'(7 * SCALE)) begin
            fails++;
            $display("FAIL idle_sop got v=%b p=%0d re=%0d exp v=1 p=0 re=%0d",
                     valid_o, wr_ptr, re_o, 7 * SCALE);
        end
    endtask

    task automatic test_resync();
        for (int i = 1; i < 7; i++) begin
            drive(1, 0, i, 0);
            step();
        end
        checks++;
        if (wr_ptr !== SZ'(6)) begin
            fails++;
            $display("FAIL pre_resync_ptr got %0d exp 6", wr_ptr);
        end
        drive(1, 1, 77, 0);
        step();
        checks++;
        if (resync_o !== 1'b1 || wr_ptr !== '0 || valid_o !== 1'b1) begin
            fails++;
            $display("FAIL resync got r=%b p=%0d v=%b exp r=1 p=0 v=1",
                     resync_o, wr_ptr, valid_o);
        end
        for (int j = 1; j < 16; j++) begin
            drive(1, 0, j, 0);
            step();
            checks++;
            if (wr_ptr !== SZ'(rev_tab[j]) || resync_o !== 1'b0 ||
                start_o !== 1'b0) begin
                fails++;
                $display("FAIL resync_fill j=%0d got p=%0d r=%b s=%b exp p=%0d",
                         j, wr_ptr, resync_o, start_o, rev_tab[j]);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_done_in_start();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        checks++;
        if (start_o !== 1'b1 || src_if.ready !== 1'b0) begin
            fails++;
            $display("FAIL dis_start got s=%b r=%b exp s=1 r=0",
                     start_o, src_if.ready);
        end
        step();
        checks++;
        if (src_if.ready !== 1'b1 || start_o !== 1'b0) begin
            fails++;
            $display("FAIL dis_ready got r=%b s=%b exp r=1 s=0",
                     src_if.ready, start_o);
        end
    endtask

    task automatic test_prescale();
        drive(1, 1, -32768, 32767);
        step();
        checks++;
        if (re_o !== BW'(EXP_MIN) || im_o !== BW'(EXP_MAX)) begin
            fails++;
            $display("FAIL prescale got %0d %0d exp %0d %0d",
                     re_o, im_o, EXP_MIN, EXP_MAX);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 10; i++) begin
            drive(1, 0, i, i);
            step();
        end
        drive(1, 0, 10, 10);
        rst_n = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b0 || start_o !== 1'b0 || resync_o !== 1'b0 ||
            src_if.ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_ctrl got v=%b s=%b r=%b rdy=%b exp 0000",
                     valid_o, start_o, resync_o, src_if.ready);
        end
        checks++;
        if (re_o !== '0 || im_o !== '0 || wr_ptr !== '0) begin
            fails++;
            $display("FAIL mid_reset_data got %0d %0d %0d exp 0 0 0",
                     re_o, im_o, wr_ptr);
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (start_o !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_start k=%0d got 1 exp 0", k);
            end
        end
        checks++;
        if (src_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_ready got 0 exp 1");
        end
    endtask

    task automatic test_back_to_back();
        int starts;
        starts = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, i == 0, 3 * i, i);
            step();
            checks++;
            if (valid_o !== 1'b1 || wr_ptr !== SZ'(rev_tab[i])) begin
                fails++;
                $display("FAIL b2b_ptr i=%0d got v=%b p=%0d exp v=1 p=%0d",
                         i, valid_o, wr_ptr, rev_tab[i]);
            end
        end
        drive(0, 0, 0, 0);
        frame_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            frame_done = 1'b0;
            if (start_o === 1'b1) starts++;
        end
        checks++;
        if (starts != 1) begin
            fails++;
            $display("FAIL b2b_start_count got %0d exp 1", starts);
        end
        checks++;
        if (src_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready got 0 exp 1");
        end
        drive(1, 1, 9, 9);
        step();
        checks++;
        if (valid_o !== 1'b1 || wr_ptr !== '0 || re_o !== BW'(9 * SCALE)) begin
            fails++;
            $display("FAIL b2b_next got v=%b p=%0d re=%0d exp v=1 p=0 re=%0d",
                     valid_o, wr_ptr, re_o, 9 * SCALE);
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_idle_discard();
        test_resync();
        test_done_in_start();
        test_prescale();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
